// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl: initiator-side controller for port 0 (1RW) of the
// 32x512 OpenRAM SRAM macro. It turns a valid/ready request stream and a
// valid/ready response stream into the macro's registered
// csb/web/wmask/addr/din protocol, and captures dout0 one edge after the
// macro's capture edge.
//
// Optional feature macro: SRAM_CTRL_INIT_EN
//   When defined, the block clears every word of the macro to zero after
//   reset and only then becomes ready.
//   When undefined, there is no clear pass, reset goes straight to IDLE,
//   and the memory contents after reset are undefined.
//
// Handshake rules (identical on both streams): a transfer happens on the
// rising clock edge where valid && ready are both high. A producer must keep
// valid and its payload stable until that edge. ready never depends on
// valid: req_ready is a decode of the state register only.
//
// DATA_WIDTH must equal NUM_WMASKS*8, so that each wmask bit covers one byte.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [NUM_WMASKS-1:0] mem_wmask0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  typedef enum logic [2:0] {
`ifdef SRAM_CTRL_INIT_EN
    ST_INIT     = 3'd0,
`endif
    ST_IDLE     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RSP      = 3'd4
  } state_e;

`ifdef SRAM_CTRL_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e                  state_q, state_d;
  logic                    mem_csb0_q, mem_csb0_d;
  logic                    mem_web0_q, mem_web0_d;
  logic [NUM_WMASKS-1:0]   mem_wmask0_q, mem_wmask0_d;
  logic [ADDR_WIDTH-1:0]   mem_addr0_q, mem_addr0_d;
  logic [DATA_WIDTH-1:0]   mem_din0_q, mem_din0_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef SRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
`endif

  // Next-state and next-output decode for the port sequencer.
  always_comb begin
    state_d      = state_q;
    mem_csb0_d   = mem_csb0_q;
    mem_web0_d   = mem_web0_q;
    mem_wmask0_d = mem_wmask0_q;
    mem_addr0_d  = mem_addr0_q;
    mem_din0_d   = mem_din0_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef SRAM_CTRL_INIT_EN
    init_cnt_d   = init_cnt_q;
`endif
    case (state_q)
`ifdef SRAM_CTRL_INIT_EN
      // One full-word zero write per cycle; the last address hands over to IDLE.
      ST_INIT: begin
        mem_csb0_d   = 1'b0;
        mem_web0_d   = 1'b0;
        mem_wmask0_d = '1;
        mem_addr0_d  = init_cnt_q;
        mem_din0_d   = '0;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_IDLE: begin
        if (req_valid) begin
          mem_csb0_d  = 1'b0;
          mem_addr0_d = req_addr;
          if (req_we) begin
            // Writes stay in IDLE so a stream of writes runs at one per cycle.
            mem_web0_d   = 1'b0;
            mem_wmask0_d = req_wmask;
            mem_din0_d   = req_wdata;
          end else begin
            mem_web0_d   = 1'b1;
            mem_wmask0_d = '0;
            state_d      = ST_RD_ISSUE;
          end
        end else begin
          // Deselect the macro; address/data/mask keep their last values.
          mem_csb0_d = 1'b1;
          mem_web0_d = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        // The macro latches the read on the edge that leaves this state.
        mem_csb0_d = 1'b1;
        state_d    = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        // dout0 has settled within the half cycle after the capture edge.
        rsp_rdata_d = mem_dout0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q      <= RESET_STATE;
      mem_csb0_q   <= 1'b1;
      mem_web0_q   <= 1'b1;
      mem_wmask0_q <= '0;
      mem_addr0_q  <= '0;
      mem_din0_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
`ifdef SRAM_CTRL_INIT_EN
      init_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_csb0_q   <= mem_csb0_d;
      mem_web0_q   <= mem_web0_d;
      mem_wmask0_q <= mem_wmask0_d;
      mem_addr0_q  <= mem_addr0_d;
      mem_din0_q   <= mem_din0_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef SRAM_CTRL_INIT_EN
      init_cnt_q   <= init_cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_csb0   = mem_csb0_q;
  assign mem_web0   = mem_web0_q;
  assign mem_wmask0 = mem_wmask0_q;
  assign mem_addr0  = mem_addr0_q;
  assign mem_din0   = mem_din0_q;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb_sram_port0_ctrl: bench for sram_port0_ctrl. Contains a behavioural model
// of the OpenRAM macro port (inputs latched on posedge, write on the
// following negedge, read data valid a few time units after the capture
// edge), a reference memory array updated at request acceptance, and a
// scoreboard whose expected queue is popped by an independent monitor.
module tb_sram_port0_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int NW    = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          rst0 = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          mem_csb0;
  logic          mem_web0;
  logic [NW-1:0] mem_wmask0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_din0;
  logic [DW-1:0] mem_dout0 = '0;

  sram_port0_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_wmask0(mem_wmask0),
    .mem_addr0(mem_addr0), .mem_din0(mem_din0), .mem_dout0(mem_dout0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // ---------------- SRAM macro model ----------------
  logic [DW-1:0] sram [DEPTH];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [NW-1:0] m_wmask = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;
  end

  always @(posedge clk0) begin
    m_csb   = mem_csb0;
    m_web   = mem_web0;
    m_wmask = mem_wmask0;
    m_addr  = mem_addr0;
    m_din   = mem_din0;
  end

  always @(negedge clk0) begin
    if (!m_csb && !m_web) begin
      for (int b = 0; b < NW; b++)
        if (m_wmask[b]) sram[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
    end
  end

  always @(posedge clk0) begin
    logic [AW-1:0] ra;
    if (!mem_csb0 && mem_web0) begin
      ra = mem_addr0;
      #3 mem_dout0 = sram[ra];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];
  bit            rsp_seen = 1'b0;
  bit            rand_rdy_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks read latency and data whenever a response is presented.
  always @(negedge clk0) begin
    if (rst0) begin
      rsp_seen = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: actual rsp_valid=1 rdata=%0h required no response (t=%0t)",
                 rsp_rdata, $time);
      end else begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          check("rsp_latency", 64'(cyc - lat_q[0]), 64'd2);
          check("rsp_data_first", rsp_rdata, exp_q[0]);
        end
        if (rsp_ready) begin
          check("rsp_data", rsp_rdata, exp_q.pop_front());
          void'(lat_q.pop_front());
          rsp_seen = 1'b0;
        end
      end
    end
  end

  // Random response back-pressure, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk0);
      #1;
      if (rand_rdy_en) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit we, input logic [NW-1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit expect_rsp, output int waits);
    bit rdy;
    req_valid = 1'b1;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
    waits     = 0;
    rdy       = 1'b0;
    while (!rdy && waits <= 200) begin
      @(negedge clk0);
      rdy = req_ready;
      @(posedge clk0);
      if (!rdy) waits++;
    end
    #1;
    if (!rdy) begin
      check("req_accept_timeout", 64'(waits), 64'd0);
    end else if (we) begin
      for (int b = 0; b < NW; b++)
        if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end else if (expect_rsp) begin
      exp_q.push_back(ref_mem[a]);
      lat_q.push_back(cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk0);
      n++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_csb"}, 64'(mem_csb0), 64'd1);
    check({tag, "_web"}, 64'(mem_web0), 64'd1);
    check({tag, "_wmask"}, 64'(mem_wmask0), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr0), 64'd0);
    check({tag, "_din"}, 64'(mem_din0), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Waits out the post-reset phase (clear pass if built in) and syncs to posedge+1.
  task automatic post_reset();
`ifdef SRAM_CTRL_INIT_EN
    int n = 0;
    @(negedge clk0);
    while (busy && n < 600) begin
      check("init_ready_low", 64'(req_ready), 64'd0);
      n++;
      @(negedge clk0);
    end
    check("init_busy_cycles", 64'(n), 64'd512);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    @(negedge clk0);
    check("ready_after_reset", 64'(req_ready), 64'd1);
    check("busy_after_reset", 64'(busy), 64'd0);
`endif
    @(posedge clk0);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

    // Reset and reset values.
    rst0 = 1'b1;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    check_reset_vals("reset");
    @(posedge clk0);
    #1 rst0 = 1'b0;
    post_reset();

`ifdef SRAM_CTRL_INIT_EN
    // Last address was cleared by the init pass.
    issue(1'b0, '0, 9'h1FF, '0, 1'b1, w);
    drain();
`endif

    // Full write then immediate read of the same word.
    issue(1'b1, 4'hF, 9'h005, 32'hDEADBEEF, 1'b0, w);
    issue(1'b0, 4'h0, 9'h005, '0, 1'b1, w);
    drain();

    // Partial write over a zeroed word.
    issue(1'b1, 4'hF, 9'h010, 32'h00000000, 1'b0, w);
    issue(1'b1, 4'b0101, 9'h010, 32'hAABBCCDD, 1'b0, w);
    issue(1'b0, 4'h0, 9'h010, '0, 1'b1, w);
    drain();
    check("partial_write_model", 64'(ref_mem[9'h010]), 64'h00BB00DD);

    // Response held under back-pressure, single handshake on release.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h0, 9'h005, '0, 1'b1, w);
    req_valid = 1'b0;
    @(posedge clk0);
    @(posedge clk0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk0);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk0);
    end
    #1 rsp_ready = 1'b1;
    drain();
    @(negedge clk0);
    check("hold_released_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk0);
    #1;

    // Reset while in RD_CAPT: no response may ever appear.
    issue(1'b0, 4'h0, 9'h005, '0, 1'b0, w);
    req_valid = 1'b0;
    @(posedge clk0);
    #1 rst0 = 1'b1;
    @(posedge clk0);
    @(negedge clk0);
    check_reset_vals("rd_reset");
    @(posedge clk0);
    #1 rst0 = 1'b0;
    post_reset();
    idle_cycles(5);

    // Back-to-back writes, then readback.
    for (int a = 0; a < 256; a++) begin
      issue(1'b1, 4'hF, AW'(a), $urandom, 1'b0, w);
      check("b2b_wait_cycles", 64'(w), 64'd0);
    end
    req_valid = 1'b0;
    for (int a = 0; a < 256; a++) issue(1'b0, 4'h0, AW'(a), '0, 1'b1, w);
    drain();

    // Random mix with random back-pressure.
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 2));
      issue(1'($urandom_range(0, 1)), NW'($urandom_range(0, 15)),
            AW'($urandom_range(0, 255)), $urandom, 1'b1, w);
    end
    req_valid = 1'b0;
    rand_rdy_en = 1'b0;
    @(posedge clk0);
    #2 rsp_ready = 1'b1;
    drain();
    idle_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port0_ctrl.md
# sram_port0_ctrl

Initiator-side controller for the 1RW port (port 0) of the 32x512 OpenRAM SRAM macro. Converts a valid/ready request stream and a valid/ready response stream into the macro's registered csb/web/wmask/addr/din protocol, and captures dout0 at the correct edge. It sits between a bus slave (or DMA engine) and the macro. It runs on the same clock that drives the macro's clk0.

## Interface
- DATA_WIDTH, 32, word width; must equal NUM_WMASKS*8
- ADDR_WIDTH, 9, word address width; depth = 1<<ADDR_WIDTH
- NUM_WMASKS, 4, byte-lane write-enable count
- clk0  in  1  clock; same net as the macro clk0
- rst0  in  1  reset; synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready at posedge
- req_we  in  1  1=write, 0=read
- req_wmask  in  NUM_WMASKS  byte enables for writes
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  response consumed when valid&&ready at posedge
- rsp_rdata  out  DATA_WIDTH  read data
- busy  out  1  high while not in IDLE
- mem_csb0  out  1  to macro csb0 (active low)
- mem_web0  out  1  to macro web0 (active low)
- mem_wmask0  out  NUM_WMASKS  to macro wmask0
- mem_addr0  out  ADDR_WIDTH  to macro addr0
- mem_din0  out  DATA_WIDTH  to macro din0
- mem_dout0  in  DATA_WIDTH  from macro dout0

## Operation
- All mem_* outputs, rsp_valid and rsp_rdata are registers. req_ready = (state==IDLE) is combinational from state only.
- Reset values: mem_csb0=1, mem_web0=1, mem_wmask0=0, mem_addr0=0, mem_din0=0, rsp_valid=0, rsp_rdata=0. The state resets to INIT if SRAM_CTRL_INIT_EN is defined, otherwise to IDLE.
- States: INIT, IDLE, RD_ISSUE, RD_CAPT, RSP.
- IDLE, write accepted:
  - mem_csb0<=0, mem_web0<=0, mem_wmask0/addr0/din0 <= request fields.
  - Stays in IDLE, so back-to-back writes run at 1/cycle.
- IDLE, no request: mem_csb0<=1, mem_web0<=1. The other mem_* fields hold their values.
- IDLE, read accepted: mem_csb0<=0, mem_web0<=1, mem_addr0<=req_addr, mem_wmask0<=0; go to RD_ISSUE.
- RD_ISSUE: the macro captures the read on this edge. Set mem_csb0<=1 and go to RD_CAPT.
- RD_CAPT: rsp_rdata<=mem_dout0, rsp_valid<=1; go to RSP.
- RSP: hold rsp_valid/rsp_rdata until rsp_ready. On handshake, rsp_valid<=0 and go to IDLE.
- A read issued immediately after a write returns the new data, because the macro writes on the negedge before it captures the read.
- Only one read is outstanding at a time. No request is accepted outside IDLE.

## Timing
- Write: handshake at edge E0, macro samples at E1, array updated at the negedge after E1.
- Read: handshake at E0 → rsp_valid high after E2 (2-cycle latency). Earliest next request is accepted at E4 when rsp_ready is held high.
- mem_dout0 is sampled at the posedge after the macro's capture edge. It must be stable by then: DELAY < half period.
- Reset mid-read: state goes to reset state, rsp_valid=0, no response is ever produced for that read.
- Reset on the edge after a write handshake: the macro still samples the already-registered write. That write completes.
- rsp_ready asserted while rsp_valid=0: ignored.

## Configuration
- SRAM_CTRL_INIT_EN defined:
  - After reset, INIT writes zero to every address 0..(1<<ADDR_WIDTH)-1, one per cycle, with all wmask bits set, using an ADDR_WIDTH counter.
  - It then enters IDLE, after 512 cycles at default parameters. busy=1 and req_ready=0 throughout.
  - Reset during INIT restarts from address 0.
- SRAM_CTRL_INIT_EN undefined: no INIT state or counter. Reset goes straight to IDLE and memory contents are undefined.

## Test plan
- Write addr 0x005 data 0xDEADBEEF mask 4'hF, then read 0x005 → rsp_rdata=0xDEADBEEF, rsp_valid two cycles after the read handshake.
- Write 0x00000000 to 0x010, then 0xAABBCCDD with mask 4'b0101, read 0x010 → 0x00BB00DD.
- Back-to-back writes to 0x000..0x0FF in consecutive cycles → req_ready stays 1; readback of each address returns its data.
- Read 0x005 with rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata held stable, req_ready=0; single handshake on release.
- Assert rst0 in RD_CAPT → rsp_valid=0 next cycle, all mem_* outputs at reset values, no response emitted.
- With SRAM_CTRL_INIT_EN: after reset, busy=1 for 512 cycles; read of 0x1FF → 0x00000000. Without it: req_ready=1 the first cycle after reset.
